// File: rtl/arb_burst_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_burst_mux
// Purpose  : Burst-locking 4:1 data mux sitting behind a round-robin arbiter.
//            A one-hot grant with a valid source starts a burst of
//            src_len+1 beats. The owner stays locked until its last beat is
//            accepted, then ack pulses once towards the arbiter. Beats pass
//            through a single output register with full throughput.
// Ports    : clk, rst_an         - clock, asynchronous active-low reset
//            grant[3:0]          - arbiter grant (one-hot or zero expected)
//            ack[3:0]            - burst-complete pulse, one bit per source
//            src_valid/src_data/src_len/src_ready - per-source beat interface
//            out_valid/out_data/out_src/out_last/out_ready - output stream
//            busy                - high while a burst is owned
//            err                 - sticky flag for a multi-hot grant
// Revision : 1.0 - initial release
// ============================================================================
module arb_burst_mux #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_an,
    input  logic [3:0]            grant,
    output logic [3:0]            ack,
    input  logic [3:0]            src_valid,
    input  logic [4*DATA_W-1:0]   src_data,
    input  logic [4*LEN_W-1:0]    src_len,
    output logic [3:0]            src_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int c_NUM_SRC = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_owner;
    logic [LEN_W-1:0]    r_cnt;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [1:0]          r_out_src;
    logic                r_out_last;
    logic                r_err;

    logic [DATA_W-1:0]   w_src_data [c_NUM_SRC];
    logic [LEN_W-1:0]    w_src_len  [c_NUM_SRC];
    logic [1:0]          w_grant_idx;
    logic                w_grant_onehot;
    logic                w_grant_multi;
    logic                w_burst;
    logic                w_take;
    logic                w_xfer;
    logic                w_last;
    logic [3:0]          w_owner_onehot;

    // Split the flat per-source buses into indexable arrays.
    genvar gi;
    generate
        for (gi = 0; gi < c_NUM_SRC; gi++) begin : g_unpack
            assign w_src_data[gi] = src_data[gi*DATA_W +: DATA_W];
            assign w_src_len[gi]  = src_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Grant decode; the index is only used when the grant is one-hot.
    always_comb begin
        w_grant_idx = 2'd0;
        for (int i = 0; i < c_NUM_SRC; i++) begin
            if (grant[i]) begin
                w_grant_idx = 2'(i);
            end
        end
    end

    assign w_grant_multi  = (grant & (grant - 4'd1)) != 4'd0;
    assign w_grant_onehot = (grant != 4'd0) && !w_grant_multi;

    assign w_burst        = (r_state == ST_BURST);
    // A beat may be taken when the output register is empty or draining now.
    assign w_take         = w_burst && (!r_out_valid || out_ready);
    assign w_xfer         = w_take && src_valid[r_owner];
    assign w_last         = (r_cnt == '0);
    assign w_owner_onehot = 4'b0001 << r_owner;

    assign src_ready = w_take ? w_owner_onehot : 4'd0;
    assign ack       = (w_xfer && w_last) ? w_owner_onehot : 4'd0;

    assign busy      = w_burst;
    assign err       = r_err;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_last  = r_out_last;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_state     <= ST_IDLE;
            r_owner     <= 2'd0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 2'd0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Multi-hot grants never start a burst; they only flag.
                    if (w_grant_multi) begin
                        r_err <= 1'b1;
                    end else if (w_grant_onehot && src_valid[w_grant_idx]) begin
                        r_state <= ST_BURST;
                        r_owner <= w_grant_idx;
                        r_cnt   <= w_src_len[w_grant_idx];
                    end
                end
                ST_BURST: begin
                    // Owner is locked here; grant is not looked at.
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Output register: a load wins over a drain so that a
            // simultaneous drain and load keeps one beat per cycle.
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_src_data[r_owner];
                r_out_src   <= r_owner;
                r_out_last  <= w_last;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_burst_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_burst_mux
// Purpose  : Self-checking bench for arb_burst_mux: directed scenarios with
//            cycle-exact expectations, then randomized bursts checked against
//            a beat-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_burst_mux;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic                clk;
    logic                rst_an;
    logic [3:0]          grant;
    logic [3:0]          ack;
    logic [3:0]          src_valid;
    logic [4*DATA_W-1:0] src_data;
    logic [4*LEN_W-1:0]  src_len;
    logic [3:0]          src_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_src;
    logic                out_last;
    logic                out_ready;
    logic                busy;
    logic                err;

    arb_burst_mux #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .grant     (grant),
        .ack       (ack),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_len   (src_len),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [1:0]        src;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             q[$];
    beat_t             e;
    logic [DATA_W-1:0] rd [16];
    int                rs;
    int                rl;
    int                rk;
    int                rcyc;
    int                gaps;
    logic [3:0]        rs_oh;
    logic              xfer;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic [1:0]        prev_src;
    logic              prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_src(input int i, input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
        src_data[i*DATA_W +: DATA_W] = d;
        src_len[i*LEN_W +: LEN_W]    = l;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "/busy"},      64'(busy),      64'd0);
        chk({tag, "/src_ready"}, 64'(src_ready), 64'd0);
        chk({tag, "/ack"},       64'(ack),       64'd0);
        chk({tag, "/out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "/out_data"},  64'(out_data),  64'd0);
        chk({tag, "/out_src"},   64'(out_src),   64'd0);
        chk({tag, "/out_last"},  64'(out_last),  64'd0);
        chk({tag, "/err"},       64'(err),       64'd0);
    endtask

    // One directed cycle: inputs already applied, check mid-cycle, advance.
    task automatic cyc(input string tag, input logic eb, input logic [3:0] er,
                       input logic [3:0] ea, input logic eov, input logic [DATA_W-1:0] ed,
                       input logic [1:0] es, input logic el, input logic ee);
        @(negedge clk);
        chk({tag, "/busy"},      64'(busy),      64'(eb));
        chk({tag, "/src_ready"}, 64'(src_ready), 64'(er));
        chk({tag, "/ack"},       64'(ack),       64'(ea));
        chk({tag, "/out_valid"}, 64'(out_valid), 64'(eov));
        chk({tag, "/err"},       64'(err),       64'(ee));
        if (eov) begin
            chk({tag, "/out_data"}, 64'(out_data), 64'(ed));
            chk({tag, "/out_src"},  64'(out_src),  64'(es));
            chk({tag, "/out_last"}, 64'(out_last), 64'(el));
        end
        @(posedge clk);
        #1;
    endtask

    // Output-side monitor for the random phase: stall stability and beat order.
    task automatic mon();
        @(negedge clk);
        if (prev_stall) begin
            chk("rnd_hold_valid", 64'(out_valid), 64'd1);
            chk("rnd_hold_data",  64'(out_data),  64'(prev_data));
            chk("rnd_hold_src",   64'(out_src),   64'(prev_src));
            chk("rnd_hold_last",  64'(out_last),  64'(prev_last));
        end
        if (out_valid && out_ready) begin
            chk("rnd_beat_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_out_src",  64'(out_src),  64'(e.src));
                chk("rnd_out_data", 64'(out_data), 64'(e.data));
                chk("rnd_out_last", 64'(out_last), 64'(e.last));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_src   = out_src;
        prev_last  = out_last;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_an    = 1'b0;
        grant     = 4'd0;
        src_valid = 4'd0;
        src_data  = '0;
        src_len   = '0;
        out_ready = 1'b1;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_src   = 2'd0;
        prev_last  = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_an = 1'b1;

        // Single beat burst from source 0
        grant = 4'b0001; src_valid = 4'b0001; set_src(0, 32'hA000_0001, 4'd0);
        cyc("s1_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("s1_xfer",  1, 4'b0001, 4'b0001, 0, 0, 0, 0, 0);
        grant = 4'b0000; src_valid = 4'b0000;
        cyc("s1_out",   0, 4'b0000, 4'b0000, 1, 32'hA000_0001, 2'd0, 1, 0);
        cyc("s1_drain", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

        // Four-beat burst from source 2 with two stall cycles
        grant = 4'b0100; src_valid = 4'b0100; set_src(2, 32'hB000_0000, 4'd3);
        cyc("s2_idle",   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("s2_b0",     1, 4'b0100, 4'b0000, 0, 0, 0, 0, 0);
        set_src(2, 32'hB000_0001, 4'd3); out_ready = 1'b0;
        cyc("s2_stall1", 1, 4'b0000, 4'b0000, 1, 32'hB000_0000, 2'd2, 0, 0);
        cyc("s2_stall2", 1, 4'b0000, 4'b0000, 1, 32'hB000_0000, 2'd2, 0, 0);
        out_ready = 1'b1;
        cyc("s2_b1",     1, 4'b0100, 4'b0000, 1, 32'hB000_0000, 2'd2, 0, 0);
        set_src(2, 32'hB000_0002, 4'd3);
        cyc("s2_b2",     1, 4'b0100, 4'b0000, 1, 32'hB000_0001, 2'd2, 0, 0);
        set_src(2, 32'hB000_0003, 4'd3);
        cyc("s2_b3",     1, 4'b0100, 4'b0100, 1, 32'hB000_0002, 2'd2, 0, 0);
        grant = 4'b0000; src_valid = 4'b0000;
        cyc("s2_last",   0, 4'b0000, 4'b0000, 1, 32'hB000_0003, 2'd2, 1, 0);
        cyc("s2_drain",  0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

        // Grant moves to source 3 while source 1 owns a three-beat burst
        grant = 4'b0010; src_valid = 4'b1010;
        set_src(1, 32'hC000_0000, 4'd2); set_src(3, 32'hD000_0000, 4'd0);
        cyc("s3_idle",  0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        grant = 4'b1000;
        cyc("s3_c0",    1, 4'b0010, 4'b0000, 0, 0, 0, 0, 0);
        set_src(1, 32'hC000_0001, 4'd2);
        cyc("s3_c1",    1, 4'b0010, 4'b0000, 1, 32'hC000_0000, 2'd1, 0, 0);
        set_src(1, 32'hC000_0002, 4'd2);
        cyc("s3_c2",    1, 4'b0010, 4'b0010, 1, 32'hC000_0001, 2'd1, 0, 0);
        src_valid = 4'b1000;
        cyc("s3_idle2", 0, 4'b0000, 4'b0000, 1, 32'hC000_0002, 2'd1, 1, 0);
        grant = 4'b0000;
        cyc("s3_d0",    1, 4'b1000, 4'b1000, 0, 0, 0, 0, 0);
        src_valid = 4'b0000;
        cyc("s3_dout",  0, 4'b0000, 4'b0000, 1, 32'hD000_0000, 2'd3, 1, 0);
        cyc("s3_drain", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

        // Back-to-back bursts: source 0 (two beats) then source 1 (one beat)
        grant = 4'b0001; src_valid = 4'b0011;
        set_src(0, 32'hE000_0000, 4'd1); set_src(1, 32'hF000_0000, 4'd0);
        cyc("s4_idle",   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("s4_a0",     1, 4'b0001, 4'b0000, 0, 0, 0, 0, 0);
        set_src(0, 32'hE000_0001, 4'd1);
        cyc("s4_a1",     1, 4'b0001, 4'b0001, 1, 32'hE000_0000, 2'd0, 0, 0);
        grant = 4'b0010; src_valid = 4'b0010;
        cyc("s4_bubble", 0, 4'b0000, 4'b0000, 1, 32'hE000_0001, 2'd0, 1, 0);
        grant = 4'b0000;
        cyc("s4_b0",     1, 4'b0010, 4'b0010, 0, 0, 0, 0, 0);
        src_valid = 4'b0000;
        cyc("s4_bout",   0, 4'b0000, 4'b0000, 1, 32'hF000_0000, 2'd1, 1, 0);
        cyc("s4_drain",  0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

        // Multi-hot grant: ignored, err becomes sticky
        grant = 4'b0101; src_valid = 4'b0101;
        cyc("s5_multi",  0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("s5_hold",   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
        grant = 4'b0000; src_valid = 4'b0000;
        cyc("s5_sticky", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
        grant = 4'b0001; src_valid = 4'b0001; set_src(0, 32'h5555_0000, 4'd0);
        cyc("s5_idle",   0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
        cyc("s5_xfer",   1, 4'b0001, 4'b0001, 0, 0, 0, 0, 1);
        grant = 4'b0000; src_valid = 4'b0000;
        cyc("s5_out",    0, 4'b0000, 4'b0000, 1, 32'h5555_0000, 2'd0, 1, 1);

        // Reset in the middle of a four-beat burst
        grant = 4'b0001; src_valid = 4'b0001; set_src(0, 32'h6000_0000, 4'd3);
        cyc("s6_idle", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1);
        cyc("s6_h0",   1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1);
        set_src(0, 32'h6000_0001, 4'd3);
        cyc("s6_h1",   1, 4'b0001, 4'b0000, 1, 32'h6000_0000, 2'd0, 0, 1);
        set_src(0, 32'h6000_0002, 4'd3);
        rst_an = 1'b0;
        #1;
        chk_all_zero("s6_async");
        @(negedge clk);
        chk_all_zero("s6_inrst");
        @(posedge clk);
        #1;
        grant = 4'b0000; src_valid = 4'b0000; rst_an = 1'b1;
        cyc("s6_after", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        grant = 4'b0100; src_valid = 4'b0100; set_src(2, 32'h7000_0000, 4'd0);
        cyc("s6_n_idle", 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        cyc("s6_n_xfer", 1, 4'b0100, 4'b0100, 0, 0, 0, 0, 0);
        grant = 4'b0000; src_valid = 4'b0000;
        cyc("s6_n_out",  0, 4'b0000, 4'b0000, 1, 32'h7000_0000, 2'd2, 1, 0);

        // Randomized bursts against the beat-queue model
        prev_stall = 1'b0;
        for (int b = 0; b < 40; b++) begin
            rs    = int'($urandom_range(0, 3));
            rl    = int'($urandom_range(0, 15));
            rs_oh = 4'(1 << rs);
            for (int i = 0; i < 16; i++) rd[i] = $urandom;
            rk    = 0;
            rcyc  = 0;
            grant = rs_oh;
            while (rk <= rl && rcyc < 400) begin
                src_valid = 4'($urandom);
                src_valid[rs] = ($urandom_range(0, 3) != 0);
                src_data  = {$urandom, $urandom, $urandom, $urandom};
                src_len   = 16'($urandom);
                set_src(rs, rd[rk], LEN_W'(rl));
                out_ready = ($urandom_range(0, 2) != 0);
                mon();
                xfer = src_valid[rs] && src_ready[rs];
                chk("rnd_ack", 64'(ack), 64'((xfer && rk == rl) ? rs_oh : 4'd0));
                chk("rnd_ready_other", 64'(src_ready & ~rs_oh), 64'd0);
                if (xfer) begin
                    e.src  = 2'(rs);
                    e.data = rd[rk];
                    e.last = (rk == rl);
                    q.push_back(e);
                    rk++;
                end
                @(posedge clk);
                #1;
                rcyc++;
            end
            chk("rnd_burst_done", 64'(rcyc < 400), 64'd1);
            grant = 4'b0000;
            gaps  = int'($urandom_range(0, 2));
            for (int g = 0; g < gaps; g++) begin
                src_valid = 4'($urandom);
                out_ready = ($urandom_range(0, 2) != 0);
                mon();
                chk("rnd_idle_ack", 64'(ack), 64'd0);
                chk("rnd_idle_ready", 64'(src_ready), 64'd0);
                @(posedge clk);
                #1;
            end
        end

        // Drain whatever is still in flight
        grant = 4'b0000; src_valid = 4'b0000; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mon();
            @(posedge clk);
            #1;
        end
        chk("rnd_queue_empty", 64'(q.size()), 64'd0);
        chk("rnd_final_valid", 64'(out_valid), 64'd0);
        chk("rnd_final_err",   64'(err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
